alarm_ringer: RTL and testbench

- Downstream consumer of the alarm-setting block. Compares the running BCD time against the stored alarm time (amin/ahour) and the alarm-set flag (LD_alert).
- Runs the ring / snooze / stop sequence and drives the buzzer with a 1 Hz on/off beep pattern.
- Sits between the timekeeping/alarm-setting stages and the buzzer/LED outputs.

---
 rtl/alarm_ringer_if.sv | 39 +++
 rtl/alarm_ringer.sv | 141 ++++++++++++++
 tb/tb_alarm_ringer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the timekeeping/alarm-setting side and the alarm ringer.
// The chime line exists only when ALARM_RINGER_HOURLY_CHIME_EN is defined.
interface alarm_ringer_if;
    logic       tick_1hz;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic [7:0] ahour;
    logic [7:0] amin;
    logic       LD_alert;
    logic       stop_btn;
    logic       snooze_btn;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic [3:0] snooze_cnt;
`ifdef ALARM_RINGER_HOURLY_CHIME_EN
    logic       chime;
`endif

    // No valid/ready handshake here: tick_1hz and both buttons are single-cycle
    // strobes that are consumed on the clock edge where they are high; all other
    // inputs are level signals and every output is a level held by registers.
`ifdef ALARM_RINGER_HOURLY_CHIME_EN
    modport slave  (input  tick_1hz, cur_hour, cur_min, cur_sec, ahour, amin,
                           LD_alert, stop_btn, snooze_btn,
                    output ringing, snoozing, buzzer, snooze_cnt, chime);
    modport master (output tick_1hz, cur_hour, cur_min, cur_sec, ahour, amin,
                           LD_alert, stop_btn, snooze_btn,
                    input  ringing, snoozing, buzzer, snooze_cnt, chime);
`else
    modport slave  (input  tick_1hz, cur_hour, cur_min, cur_sec, ahour, amin,
                           LD_alert, stop_btn, snooze_btn,
                    output ringing, snoozing, buzzer, snooze_cnt);
    modport master (output tick_1hz, cur_hour, cur_min, cur_sec, ahour, amin,
                           LD_alert, stop_btn, snooze_btn,
                    input  ringing, snoozing, buzzer, snooze_cnt);
`endif
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: ring / snooze / stop sequencing with a 1 Hz beep on the buzzer.
// Optional hourly chime output is enabled by defining ALARM_RINGER_HOURLY_CHIME_EN.
module alarm_ringer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alarm_ringer_if.slave  bus,
    output logic [1:0]     fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
    localparam logic [3:0] SNOOZE_MAX  = 4'(MAX_SNOOZE);

    state_t     state, state_nxt;
    logic [8:0] sec_cnt, sec_nxt;
    logic       beep_phase, beep_nxt;
    logic [3:0] snz_q, snz_nxt;

    logic time_eq;
    logic match;

    assign time_eq = (bus.cur_hour == bus.ahour) && (bus.cur_min == bus.amin);
    assign match   = bus.tick_1hz && !bus.LD_alert && time_eq && (bus.cur_sec == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            beep_phase <= 1'b0;
            snz_q      <= '0;
        end else begin
            state      <= state_nxt;
            sec_cnt    <= sec_nxt;
            beep_phase <= beep_nxt;
            snz_q      <= snz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sec_nxt   = sec_cnt;
        beep_nxt  = beep_phase;
        snz_nxt   = snz_q;
        unique case (state)
            IDLE: begin
                if (match) begin
                    state_nxt = RING;
                    sec_nxt   = '0;
                    beep_nxt  = 1'b1;
                    snz_nxt   = '0;
                end
            end
            RING: begin
                // A snooze press beyond the allowance is treated as no press at all.
                if (bus.stop_btn) begin
                    state_nxt = DONE;
                    beep_nxt  = 1'b0;
                end else if (bus.snooze_btn && (snz_q < SNOOZE_MAX)) begin
                    state_nxt = SNOOZE;
                    sec_nxt   = '0;
                    snz_nxt   = snz_q + 4'd1;
                    beep_nxt  = 1'b0;
                end else if (bus.tick_1hz) begin
                    beep_nxt = ~beep_phase;
                    if (sec_cnt == RING_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        sec_nxt = sec_cnt + 9'd1;
                    end
                end
            end
            SNOOZE: begin
                if (bus.stop_btn) begin
                    state_nxt = DONE;
                end else if (bus.tick_1hz) begin
                    if (sec_cnt == SNOOZE_LAST) begin
                        state_nxt = RING;
                        sec_nxt   = '0;
                        beep_nxt  = 1'b1;
                    end else begin
                        sec_nxt = sec_cnt + 9'd1;
                    end
                end
            end
            DONE: begin
                // Stay here until the alarm minute has passed so it cannot re-fire.
                if (!time_eq) begin
                    state_nxt = IDLE;
                end
            end
        endcase
        if ((state != IDLE) && bus.LD_alert) begin
            state_nxt = IDLE;
            sec_nxt   = '0;
            snz_nxt   = '0;
            beep_nxt  = 1'b0;
        end
    end

    always_comb begin
        bus.ringing    = (state == RING);
        bus.snoozing   = (state == SNOOZE);
        bus.buzzer     = (state == RING) && beep_phase;
        bus.snooze_cnt = snz_q;
        fsm_state      = state;
    end

`ifdef ALARM_RINGER_HOURLY_CHIME_EN
    logic chime_q;
    logic hour_mark;
    logic active_nxt;

    assign hour_mark  = (bus.cur_min == 8'h00) && (bus.cur_sec == 8'h00);
    assign active_nxt = (state_nxt == RING) || (state_nxt == SNOOZE);

    // Chime holds from one tick to the next, but never alongside the alarm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chime_q <= 1'b0;
        end else if (active_nxt) begin
            chime_q <= 1'b0;
        end else if (bus.tick_1hz) begin
            chime_q <= hour_mark && !match && (state != RING) && (state != SNOOZE);
        end
    end

    assign bus.chime = chime_q;
`endif

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed testbench for alarm_ringer with default parameters (60 / 300 / 3).
// Chime checks are compiled in when ALARM_RINGER_HOURLY_CHIME_EN is defined.
module tb_alarm_ringer;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;
    int         total;
    int         bad;

    alarm_ringer_if bus ();

    alarm_ringer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive strobes at a falling edge and hold them for one clock.
    task automatic step(input logic t, input logic stp, input logic snz);
        bus.tick_1hz   = t;
        bus.stop_btn   = stp;
        bus.snooze_btn = snz;
        @(negedge clk);
        bus.tick_1hz   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL reset_ringing got=%b exp=0", bus.ringing); end
        total++; if (bus.snoozing !== 1'b0) begin bad++; $display("FAIL reset_snoozing got=%b exp=0", bus.snoozing); end
        total++; if (bus.buzzer !== 1'b0) begin bad++; $display("FAIL reset_buzzer got=%b exp=0", bus.buzzer); end
        total++; if (bus.snooze_cnt !== 4'd0) begin bad++; $display("FAIL reset_snooze_cnt got=%0d exp=0", bus.snooze_cnt); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ring_timeout();
        bus.ahour = 8'h07; bus.amin = 8'h30; bus.LD_alert = 1'b0;
        set_time(8'h07, 8'h29, 8'h59);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL early_ring got=%b exp=0", bus.ringing); end
        set_time(8'h07, 8'h30, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL ring_start got=%b exp=1", bus.ringing); end
        total++; if (bus.buzzer !== 1'b1) begin bad++; $display("FAIL ring_start_buzzer got=%b exp=1", bus.buzzer); end
        set_time(8'h07, 8'h30, 8'h01);
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (bus.ringing !== logic'(k < 60)) begin
                bad++; $display("FAIL ring_tick%0d_ringing got=%b exp=%b", k, bus.ringing, k < 60);
            end
            total++;
            if (bus.buzzer !== logic'((k < 60) && (k % 2 == 0))) begin
                bad++; $display("FAIL ring_tick%0d_buzzer got=%b exp=%b", k, bus.buzzer, (k < 60) && (k % 2 == 0));
            end
        end
        total++; if (fsm_state !== 2'd3) begin bad++; $display("FAIL timeout_done got=%0d exp=3", fsm_state); end
        set_time(8'h07, 8'h30, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL no_retrigger got=%b exp=0", bus.ringing); end
        set_time(8'h07, 8'h31, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL done_to_idle got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_snooze();
        set_time(8'h07, 8'h30, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        set_time(8'h07, 8'h30, 8'h01);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 3; r++) begin
            step(1'b0, 1'b0, 1'b1);
            total++; if (bus.snoozing !== 1'b1) begin bad++; $display("FAIL snooze%0d_snoozing got=%b exp=1", r, bus.snoozing); end
            total++; if (bus.snooze_cnt !== 4'(r)) begin bad++; $display("FAIL snooze%0d_cnt got=%0d exp=%0d", r, bus.snooze_cnt, r); end
            total++; if (bus.buzzer !== 1'b0) begin bad++; $display("FAIL snooze%0d_buzzer got=%b exp=0", r, bus.buzzer); end
            for (int k = 0; k < 299; k++) step(1'b1, 1'b0, 1'b0);
            total++; if (bus.snoozing !== 1'b1) begin bad++; $display("FAIL snooze%0d_hold got=%b exp=1", r, bus.snoozing); end
            step(1'b1, 1'b0, 1'b0);
            total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL snooze%0d_rering got=%b exp=1", r, bus.ringing); end
            total++; if (bus.buzzer !== 1'b1) begin bad++; $display("FAIL snooze%0d_beep got=%b exp=1", r, bus.buzzer); end
        end
        step(1'b0, 1'b0, 1'b1);
        total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL max_snooze_ringing got=%b exp=1", bus.ringing); end
        total++; if (bus.snooze_cnt !== 4'd3) begin bad++; $display("FAIL max_snooze_cnt got=%0d exp=3", bus.snooze_cnt); end
        step(1'b0, 1'b1, 1'b0);
        total++; if (fsm_state !== 2'd3) begin bad++; $display("FAIL stop_done got=%0d exp=3", fsm_state); end
        total++; if (bus.snooze_cnt !== 4'd3) begin bad++; $display("FAIL stop_cnt_hold got=%0d exp=3", bus.snooze_cnt); end
        set_time(8'h07, 8'h31, 8'h00);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stop_and_snooze();
        bus.ahour = 8'h12; bus.amin = 8'h00;
        set_time(8'h12, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL noon_ring got=%b exp=1", bus.ringing); end
        total++; if (bus.snooze_cnt !== 4'd0) begin bad++; $display("FAIL noon_cnt_clear got=%0d exp=0", bus.snooze_cnt); end
        step(1'b1, 1'b1, 1'b1);
        total++; if (fsm_state !== 2'd3) begin bad++; $display("FAIL both_btn_done got=%0d exp=3", fsm_state); end
        total++; if (bus.snooze_cnt !== 4'd0) begin bad++; $display("FAIL both_btn_cnt got=%0d exp=0", bus.snooze_cnt); end
        set_time(8'h12, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        set_time(8'h12, 8'h00, 8'h30);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL noon_no_rering got=%b exp=0", bus.ringing); end
        set_time(8'h12, 8'h01, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        set_time(8'h12, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL next_day_ring got=%b exp=1", bus.ringing); end
    endtask

    task automatic test_ld_alert_abort();
        set_time(8'h12, 8'h00, 8'h01);
        step(1'b0, 1'b0, 1'b1);
        total++; if (bus.snoozing !== 1'b1) begin bad++; $display("FAIL ld_pre_snooze got=%b exp=1", bus.snoozing); end
        bus.LD_alert = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL ld_abort_state got=%0d exp=0", fsm_state); end
        total++; if (bus.snooze_cnt !== 4'd0) begin bad++; $display("FAIL ld_abort_cnt got=%0d exp=0", bus.snooze_cnt); end
        total++; if (bus.snoozing !== 1'b0) begin bad++; $display("FAIL ld_abort_snoozing got=%b exp=0", bus.snoozing); end
        bus.ahour = 8'h00; bus.amin = 8'h00;
        set_time(8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL midnight_ring%0d got=%b exp=0", k, bus.ringing); end
        end
        bus.LD_alert = 1'b0;
    endtask

    task automatic test_reset_mid_ring();
        bus.ahour = 8'h06; bus.amin = 8'h15;
        set_time(8'h06, 8'h15, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.buzzer !== 1'b1) begin bad++; $display("FAIL pre_rst_buzzer got=%b exp=1", bus.buzzer); end
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.ringing !== 1'b0) begin bad++; $display("FAIL rst_ring_ringing got=%b exp=0", bus.ringing); end
        total++; if (bus.buzzer !== 1'b0) begin bad++; $display("FAIL rst_ring_buzzer got=%b exp=0", bus.buzzer); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_ring_state got=%0d exp=0", fsm_state); end
        rst_n = 1'b1;
        set_time(8'h06, 8'h16, 8'h00);
        step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef ALARM_RINGER_HOURLY_CHIME_EN
    task automatic test_chime();
        bus.ahour = 8'h07; bus.amin = 8'h30; bus.LD_alert = 1'b0;
        set_time(8'h09, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.chime !== 1'b1) begin bad++; $display("FAIL chime_on got=%b exp=1", bus.chime); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (bus.chime !== 1'b1) begin bad++; $display("FAIL chime_hold got=%b exp=1", bus.chime); end
        set_time(8'h09, 8'h00, 8'h01);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.chime !== 1'b0) begin bad++; $display("FAIL chime_off got=%b exp=0", bus.chime); end
        bus.ahour = 8'h09; bus.amin = 8'h00;
        set_time(8'h09, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        total++; if (bus.chime !== 1'b0) begin bad++; $display("FAIL chime_suppr got=%b exp=0", bus.chime); end
        total++; if (bus.ringing !== 1'b1) begin bad++; $display("FAIL chime_alarm_ring got=%b exp=1", bus.ringing); end
        step(1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.tick_1hz = 1'b0; bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
        bus.LD_alert = 1'b1; bus.ahour = 8'h00; bus.amin = 8'h00;
        set_time(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_ld_alert_abort();
        test_reset_mid_ring();
`ifdef ALARM_RINGER_HOURLY_CHIME_EN
        test_chime();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
